// File: rtl/csa_product_accumulator.sv
// Product accumulator: sums bursts of 8-bit multiplier products into one result held on a valid/ready output.
// Define ACC_SAT_EN to saturate the accumulator with a sticky overflow flag; otherwise it wraps and out_ovf is 0.
module csa_product_accumulator #(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     in_prod,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [ACC_W-1:0]               out_sum,
    output logic [$clog2(MAX_LEN+1)-1:0]   out_count,
    output logic                           out_ovf,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [ACC_W-1:0]   prod_ext;

    assign prod_ext = {{(ACC_W-8){1'b0}}, in_prod};
    assign cnt_d    = cnt_q + CNT_W'(1);

`ifdef ACC_SAT_EN
    logic [ACC_W:0]     sum_w;
    logic               ovf_q;
    logic               ovf_d;

    // Once saturated, further adds keep carrying out (or land exactly on max), so acc stays pinned.
    always_comb begin
        sum_w = {1'b0, acc_q} + {1'b0, prod_ext};
        acc_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
        ovf_d = ovf_q | sum_w[ACC_W];
    end

    assign out_ovf = ovf_q;
`else
    always_comb begin
        acc_d = acc_q + prod_ext;
    end

    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef ACC_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q   <= prod_ext;
                        cnt_q   <= CNT_W'(1);
`ifdef ACC_SAT_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= in_last ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
`ifdef ACC_SAT_EN
                        ovf_q <= ovf_d;
`endif
                        if (in_last || (cnt_d == CNT_W'(MAX_LEN))) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_product_accumulator.sv
// Scoreboard bench for csa_product_accumulator: directed scenarios plus random bursts against a burst-level reference model.
module tb_csa_product_accumulator;

    localparam int unsigned ACC_W   = 10;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned CW      = $clog2(MAX_LEN + 1);

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_prod;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CW-1:0]     out_count;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    csa_product_accumulator #(
        .ACC_W   (ACC_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        longint sum;
        longint cnt;
        longint ovf;
    } exp_t;

    exp_t         expq[$];
    int unsigned  terms[$];
    bit           m_hold;
    int           errors = 0;
    int           checks = 0;
    int           ready_mode = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Burst result from plain arithmetic over all terms: partial sums only grow, so saturation == total above max.
    function automatic exp_t close_burst();
        exp_t   e;
        longint total = 0;
        longint maxv  = (longint'(1) << ACC_W) - 1;
        foreach (terms[i]) total += terms[i];
        e.cnt = terms.size();
`ifdef ACC_SAT_EN
        e.sum = (total > maxv) ? maxv : total;
        e.ovf = (total > maxv) ? 1 : 0;
`else
        e.sum = total % (longint'(1) << ACC_W);
        e.ovf = 0;
`endif
        return e;
    endfunction

    // Reference model: collects accepted terms, closes a burst on in_last or MAX_LEN terms, then waits for the sink.
    initial begin
        m_hold = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                terms.delete();
                expq.delete();
                m_hold = 1'b0;
            end else if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (in_valid) begin
                terms.push_back(int'(in_prod));
                if (in_last || terms.size() == MAX_LEN) begin
                    expq.push_back(close_burst());
                    terms.delete();
                    m_hold = 1'b1;
                end
            end
        end
    end

    // Monitor: compares everything the DUT presents against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_sum", out_sum, 0);
                chk("rst_out_count", out_count, 0);
                chk("rst_out_ovf", out_ovf, 0);
            end else begin
                chk("in_ready", in_ready, !m_hold);
                chk("out_valid", out_valid, m_hold);
                if (m_hold || out_valid) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: out_valid=%0d with empty scoreboard at %0t", out_valid, $time);
                    end else begin
                        chk("out_sum", out_sum, expq[0].sum);
                        chk("out_count", out_count, expq[0].cnt);
                        chk("out_ovf", out_ovf, expq[0].ovf);
                        if (m_hold && out_ready) void'(expq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic beat(input logic [7:0] p, input logic l);
        bit go;
        int guard;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        go       = 1'b0;
        guard    = 0;
        do begin
            @(negedge clk);
            go = !m_hold;
            @(posedge clk);
            #1;
            guard++;
        end while (!go && guard < 200);
        if (!go) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: beat %0d not accepted within %0d cycles", p, guard);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_prod  = '0;
        in_last  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        beat(8'd15, 1'b0);
        beat(8'd14, 1'b0);
        beat(8'd225, 1'b1);
        idle(3);

        for (int i = 0; i < 5; i++) beat(8'd225, 1'(i == 4));
        idle(3);

        for (int i = 1; i <= 20; i++) beat(8'd1, 1'(i == 20));
        idle(3);

        ready_mode = 0;
        beat(8'd15, 1'b0);
        beat(8'd14, 1'b0);
        beat(8'd225, 1'b1);
        in_valid = 1'b1;
        in_prod  = 8'd77;
        in_last  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        ready_mode = 1;
        beat(8'd77, 1'b1);
        idle(3);

        beat(8'd0, 1'b1);
        idle(3);

        beat(8'd7, 1'b0);
        beat(8'd9, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        beat(8'd5, 1'b1);
        idle(3);

        ready_mode = 2;
        for (int b = 0; b < 40; b++) begin
            int unsigned len;
            len = $urandom_range(1, 20);
            for (int unsigned j = 0; j < len; j++) begin
                int unsigned gap;
                logic [7:0]  p;
                gap = $urandom_range(0, 2);
                if (gap != 0) idle(int'(gap));
                p = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
                beat(p, 1'(j == len - 1));
            end
        end

        ready_mode = 1;
        idle(10);
        chk("drain_pending_results", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
